// File: rtl/config_loader.sv
// config_loader: byte-stream parser that frames 32-bit tile config writes.
// Define CFG_CHECKSUM_EN to add a trailing XOR check byte to every frame.
`timescale 1ns/1ps
module config_loader #(
  parameter int         NUM_TILES = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] END_ADDR  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 cfg_done,
  output logic                 frame_err,
  output logic [15:0]          frame_count
);

`ifdef CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4,
    S_CHK    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_addr;
  logic [1:0]  r_idx;
  logic [23:0] r_asm;

  logic [31:0]          r_config_data;
  logic [NUM_TILES-1:0] r_config_en;
  logic                 r_cfg_done;
  logic                 r_frame_err;
  logic [15:0]          r_frame_count;

  logic                 w_in_ready;
  logic                 w_xfer;
  logic                 w_last_byte;
  logic                 w_enter;
  logic                 w_chk_ok;
  logic                 w_addr_ok;
  logic                 w_tile_hit;
  logic                 w_end_hit;
  logic                 w_bad;
  logic [31:0]          w_word;
  logic [NUM_TILES-1:0] w_onehot;

  assign w_xfer      = in_valid && w_in_ready;
  assign w_last_byte = (r_state == S_DATA) && w_xfer && (r_idx == 2'd3);

`ifdef CFG_CHECKSUM_EN
  logic [7:0] r_d3;
  logic [7:0] r_chk;

  // Commit decision is taken on the check byte; D3 was parked in r_d3.
  assign w_enter  = (r_state == S_CHK) && w_xfer;
  assign w_chk_ok = (in_data == r_chk);
  assign w_word   = {r_d3, r_asm};
`else
  // Commit decision is taken on D3 itself so the word lands one cycle later.
  assign w_enter  = w_last_byte;
  assign w_chk_ok = 1'b1;
  assign w_word   = {in_data, r_asm};
`endif

  assign w_addr_ok  = (32'(r_addr) < 32'(NUM_TILES));
  assign w_onehot   = NUM_TILES'(1) << r_addr;
  assign w_tile_hit = w_enter && w_chk_ok && w_addr_ok;
  assign w_end_hit  = w_enter && w_chk_ok && !w_addr_ok
                      && (r_addr == END_ADDR);
  assign w_bad      = w_enter && !w_tile_hit && !w_end_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HUNT: begin
        if (w_xfer && (in_data == SYNC_BYTE)) begin
          w_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_xfer) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last_byte) begin
`ifdef CFG_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_COMMIT;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) begin
          w_next = S_COMMIT;
        end
      end
`endif
      S_COMMIT: begin
        w_next = r_cfg_done ? S_DONE : S_HUNT;
      end
      S_DONE: begin
        w_next = S_DONE;
      end
      default: begin
        w_next = S_HUNT;
      end
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_HUNT:   w_in_ready = 1'b1;
      S_ADDR:   w_in_ready = 1'b1;
      S_DATA:   w_in_ready = 1'b1;
`ifdef CFG_CHECKSUM_EN
      S_CHK:    w_in_ready = 1'b1;
`endif
      default:  w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 8'd0;
      r_idx  <= 2'd0;
      r_asm  <= 24'd0;
`ifdef CFG_CHECKSUM_EN
      r_d3   <= 8'd0;
      r_chk  <= 8'd0;
`endif
    end else if (w_xfer) begin
      if (r_state == S_ADDR) begin
        r_addr <= in_data;
        r_idx  <= 2'd0;
`ifdef CFG_CHECKSUM_EN
        r_chk  <= in_data;
`endif
      end
      if (r_state == S_DATA) begin
        r_idx <= r_idx + 2'd1;
`ifdef CFG_CHECKSUM_EN
        r_chk <= r_chk ^ in_data;
`endif
        case (r_idx)
          2'd0:    r_asm[7:0]   <= in_data;
          2'd1:    r_asm[15:8]  <= in_data;
          2'd2:    r_asm[23:16] <= in_data;
          default: begin
`ifdef CFG_CHECKSUM_EN
            r_d3 <= in_data;
`endif
          end
        endcase
      end
    end
  end

  // All frame outcomes are registered on entry to COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_config_data <= 32'd0;
      r_config_en   <= '0;
      r_cfg_done    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_config_en <= '0;
      r_frame_err <= 1'b0;
      if (w_tile_hit) begin
        r_config_data <= w_word;
        r_config_en   <= w_onehot;
        if (r_frame_count != 16'hFFFF) begin
          r_frame_count <= r_frame_count + 16'd1;
        end
      end
      if (w_end_hit) begin
        r_cfg_done <= 1'b1;
      end
      if (w_bad) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign config_data = r_config_data;
  assign config_en   = r_config_en;
  assign cfg_done    = r_cfg_done;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;

endmodule
